// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: 640x480@60 VGA timing generator and pixel fetcher.
// Requests pixel (pix_x, pix_y) one clock ahead of display, passes pix_data
// through to rgb inside the active window, and drives active-low syncs.
// Optional feature macro: VGA_FRAME_START_EN adds frame_start / frame_cnt.
module vga_timing_ctrl #(
   parameter int unsigned H_SYNC  = 96,
   parameter int unsigned H_BACK  = 48,
   parameter int unsigned H_VALID = 640,
   parameter int unsigned H_FRONT = 16,
   parameter int unsigned V_SYNC  = 2,
   parameter int unsigned V_BACK  = 33,
   parameter int unsigned V_VALID = 480,
   parameter int unsigned V_FRONT = 10
) (
   input  logic        vga_clk,
   input  logic        sys_rst,
   input  logic [15:0] pix_data,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        hsync,
   output logic        vsync,
   output logic        rgb_valid,
   output logic [15:0] rgb
`ifdef VGA_FRAME_START_EN
   ,
   output logic        frame_start,
   output logic [7:0]  frame_cnt
`endif
);

   localparam logic [9:0] H_TOTAL  = 10'(H_SYNC + H_BACK + H_VALID + H_FRONT);
   localparam logic [9:0] V_TOTAL  = 10'(V_SYNC + V_BACK + V_VALID + V_FRONT);
   localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
   localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
   localparam logic [9:0] HA       = 10'(H_SYNC + H_BACK);
   localparam logic [9:0] VA       = 10'(V_SYNC + V_BACK);
   localparam logic [9:0] H_ACT_HI = 10'(H_SYNC + H_BACK + H_VALID);
   localparam logic [9:0] V_ACT_HI = 10'(V_SYNC + V_BACK + V_VALID);
   localparam logic [9:0] H_REQ_LO = 10'(H_SYNC + H_BACK - 1);
   localparam logic [9:0] H_REQ_HI = 10'(H_SYNC + H_BACK + H_VALID - 1);

   logic [9:0] cnt_h_q, cnt_h_d;
   logic [9:0] cnt_v_q, cnt_v_d;
   logic       v_act;
   logic       h_act;
   logic       h_req;
   logic       pix_req;

   // Horizontal / vertical counter next-state: line wrap advances the row
   always_comb begin
      cnt_h_d = cnt_h_q + 10'd1;
      cnt_v_d = cnt_v_q;
      if (cnt_h_q == H_TOTAL - 10'd1) begin
         cnt_h_d = '0;
         if (cnt_v_q == V_TOTAL - 10'd1) begin
            cnt_v_d = '0;
         end else begin
            cnt_v_d = cnt_v_q + 10'd1;
         end
      end
   end

   // Counter registers; reset restarts the frame at the vsync pulse
   always_ff @(posedge vga_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt_h_q <= '0;
         cnt_v_q <= '0;
      end else begin
         cnt_h_q <= cnt_h_d;
         cnt_v_q <= cnt_v_d;
      end
   end

   // Output decode from the registered counters; rgb is the only path from pix_data
   always_comb begin
      v_act     = (cnt_v_q >= VA) && (cnt_v_q < V_ACT_HI);
      h_act     = (cnt_h_q >= HA) && (cnt_h_q < H_ACT_HI);
      // request window is the display window shifted one clock earlier
      h_req     = (cnt_h_q >= H_REQ_LO) && (cnt_h_q < H_REQ_HI);
      pix_req   = h_req && v_act;
      hsync     = (cnt_h_q >= H_SYNC_C);
      vsync     = (cnt_v_q >= V_SYNC_C);
      rgb_valid = h_act && v_act;
      pix_x     = pix_req ? (cnt_h_q - H_REQ_LO) : '1;
      pix_y     = pix_req ? (cnt_v_q - VA) : '1;
      rgb       = rgb_valid ? pix_data : '0;
   end

`ifdef VGA_FRAME_START_EN
   logic       started_q, started_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;

   // Frame marker: counter origin, masked for the first clock out of reset
   always_comb begin
      started_d   = 1'b1;
      frame_start = started_q && (cnt_h_q == '0) && (cnt_v_q == '0);
      frame_cnt_d = frame_start ? frame_cnt_q + 8'd1 : frame_cnt_q;
      frame_cnt   = frame_cnt_q;
   end

   // Frame marker state registers
   always_ff @(posedge vga_clk or posedge sys_rst) begin
      if (sys_rst) begin
         started_q   <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         started_q   <= started_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end
`endif

endmodule
